// File: rtl/res_station_bank_pkg.sv
// Shared types for the reservation-station bank: entry states, the
// "no producer" tag and the per-entry payload record.
package rs_pkg;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int OP_W   = 3;
  localparam int IMM_W  = 7;
  localparam int RD_W   = 3;

  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  typedef enum logic [1:0] {
    RS_FREE  = 2'd0,
    RS_WAIT  = 2'd1,
    RS_READY = 2'd2,
    RS_EXEC  = 2'd3
  } rs_state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic [IMM_W-1:0]  a;
    logic [RD_W-1:0]   rd;
  } rs_rec_t;
endpackage

// File: rtl/res_station_bank_entry.sv
// One reservation-station entry: lifecycle FREE->WAIT/READY->EXEC->FREE,
// with issue-time CDB forwarding and CDB operand capture while waiting.
module rs_entry
  import rs_pkg::*;
#(
  parameter int               DATA_W = 16,
  parameter int               TAG_W  = 3,
  parameter int               OP_W   = 3,
  parameter int               IMM_W  = 7,
  parameter logic [TAG_W-1:0] MY_TAG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [IMM_W-1:0]  issue_a,
  input  logic [2:0]        issue_rd,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              disp_fire,
  input  logic              fu_done,
  input  logic [TAG_W-1:0]  fu_tag,
  output rs_state_e         state,
  output logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] vj,
  output logic [DATA_W-1:0] vk,
  output logic [IMM_W-1:0]  a,
  output logic [2:0]        rd
);
  localparam logic [TAG_W-1:0] NONE = TAG_W'(TAG_NONE);

  rs_state_e         state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;
  logic [TAG_W-1:0]  qj_q, qj_d, qk_q, qk_d;
  logic [IMM_W-1:0]  a_q, a_d;
  logic [2:0]        rd_q, rd_d;
  logic              hit_j, hit_k, fwd_j, fwd_k;

  // Tag 0 never matches: it marks an operand that is already valid.
  assign hit_j = cdb_valid && (qj_q != NONE) && (qj_q == cdb_tag);
  assign hit_k = cdb_valid && (qk_q != NONE) && (qk_q == cdb_tag);
  assign fwd_j = cdb_valid && (issue_qj != NONE) && (issue_qj == cdb_tag);
  assign fwd_k = cdb_valid && (issue_qk != NONE) && (issue_qk == cdb_tag);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    vj_d    = vj_q;
    vk_d    = vk_q;
    qj_d    = qj_q;
    qk_d    = qk_q;
    a_d     = a_q;
    rd_d    = rd_q;
    case (state_q)
      RS_FREE: begin
        if (alloc) begin
          op_d    = issue_op;
          vj_d    = fwd_j ? cdb_value : issue_vj;
          qj_d    = fwd_j ? NONE : issue_qj;
          vk_d    = fwd_k ? cdb_value : issue_vk;
          qk_d    = fwd_k ? NONE : issue_qk;
          a_d     = issue_a;
          rd_d    = issue_rd;
          state_d = (qj_d == NONE && qk_d == NONE) ? RS_READY : RS_WAIT;
        end
      end
      RS_WAIT: begin
        if (hit_j) begin
          vj_d = cdb_value;
          qj_d = NONE;
        end
        if (hit_k) begin
          vk_d = cdb_value;
          qk_d = NONE;
        end
        if (qj_d == NONE && qk_d == NONE) state_d = RS_READY;
      end
      RS_READY: begin
        if (disp_fire) state_d = RS_EXEC;
      end
      RS_EXEC: begin
        if (fu_done && fu_tag == MY_TAG) begin
          state_d = RS_FREE;
          op_d    = '0;
          vj_d    = '0;
          vk_d    = '0;
          qj_d    = NONE;
          qk_d    = NONE;
          a_d     = '0;
          rd_d    = '0;
        end
      end
      default: state_d = RS_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RS_FREE;
      op_q    <= '0;
      vj_q    <= '0;
      vk_q    <= '0;
      qj_q    <= NONE;
      qk_q    <= NONE;
      a_q     <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vj_q    <= vj_d;
      vk_q    <= vk_d;
      qj_q    <= qj_d;
      qk_q    <= qk_d;
      a_q     <= a_d;
      rd_q    <= rd_d;
    end
  end

  assign state = state_q;
  assign op    = op_q;
  assign vj    = vj_q;
  assign vk    = vk_q;
  assign a     = a_q;
  assign rd    = rd_q;
endmodule

// File: rtl/res_station_bank.sv
// Multi-entry reservation station: lowest-free allocation, CDB wake-up in
// each entry, lowest-ready dispatch to one shared functional unit.
module res_station_bank
  import rs_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 3,
  parameter int OP_W     = 3,
  parameter int IMM_W    = 7,
  parameter int DEPTH    = 4,
  parameter int BASE_TAG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [OP_W-1:0]    issue_op,
  input  logic [DATA_W-1:0]  issue_vj,
  input  logic [DATA_W-1:0]  issue_vk,
  input  logic [TAG_W-1:0]   issue_qj,
  input  logic [TAG_W-1:0]   issue_qk,
  input  logic [IMM_W-1:0]   issue_a,
  input  logic [2:0]         issue_rd,
  output logic [TAG_W-1:0]   issue_tag,
  input  logic               cdb_valid,
  input  logic [TAG_W-1:0]   cdb_tag,
  input  logic [DATA_W-1:0]  cdb_value,
  output logic               disp_valid,
  input  logic               disp_ready,
  output logic [OP_W-1:0]    disp_op,
  output logic [DATA_W-1:0]  disp_vj,
  output logic [DATA_W-1:0]  disp_vk,
  output logic [IMM_W-1:0]   disp_a,
  output logic [2:0]         disp_rd,
  output logic [TAG_W-1:0]   disp_tag,
  input  logic               fu_done,
  input  logic [TAG_W-1:0]   fu_tag,
  output logic [DEPTH-1:0]   busy_vec,
  output logic               full,
  output logic [2*DEPTH-1:0] state_dbg
);
  localparam int IDX_W = 3;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Both ready (issue) and valid (dispatch) come only from registered
  // state, so no combinational path runs through this block.
  rs_state_e         st   [DEPTH];
  logic [OP_W-1:0]   op_e [DEPTH];
  logic [DATA_W-1:0] vj_e [DEPTH];
  logic [DATA_W-1:0] vk_e [DEPTH];
  logic [IMM_W-1:0]  a_e  [DEPTH];
  logic [2:0]        rd_e [DEPTH];

  logic             free_found, issue_fire, disp_fire;
  logic [IDX_W-1:0] alloc_idx, disp_idx;

  always_comb begin
    free_found = 1'b0;
    alloc_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (st[i] == RS_FREE) begin
        free_found = 1'b1;
        alloc_idx  = IDX_W'(i);
      end
    end
  end

  assign issue_ready = free_found;
  assign full        = ~free_found;
  assign issue_tag   = TAG_W'(BASE_TAG) + TAG_W'(alloc_idx);
  assign issue_fire  = issue_valid && free_found;

  // Descending scan so the lowest-index READY entry is the one left driving.
  always_comb begin
    disp_valid = 1'b0;
    disp_idx   = '0;
    disp_op    = '0;
    disp_vj    = '0;
    disp_vk    = '0;
    disp_a     = '0;
    disp_rd    = '0;
    disp_tag   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (st[i] == RS_READY) begin
        disp_valid = 1'b1;
        disp_idx   = IDX_W'(i);
        disp_op    = op_e[i];
        disp_vj    = vj_e[i];
        disp_vk    = vk_e[i];
        disp_a     = a_e[i];
        disp_rd    = rd_e[i];
        disp_tag   = TAG_W'(BASE_TAG + i);
      end
    end
  end

  assign disp_fire = disp_valid && disp_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    rs_entry #(
      .DATA_W(DATA_W),
      .TAG_W (TAG_W),
      .OP_W  (OP_W),
      .IMM_W (IMM_W),
      .MY_TAG(TAG_W'(BASE_TAG + g))
    ) u_entry (
      .clk      (clk),
      .rst      (rst),
      .alloc    (issue_fire && (alloc_idx == IDX_W'(g))),
      .issue_op (issue_op),
      .issue_vj (issue_vj),
      .issue_vk (issue_vk),
      .issue_qj (issue_qj),
      .issue_qk (issue_qk),
      .issue_a  (issue_a),
      .issue_rd (issue_rd),
      .cdb_valid(cdb_valid),
      .cdb_tag  (cdb_tag),
      .cdb_value(cdb_value),
      .disp_fire(disp_fire && (disp_idx == IDX_W'(g))),
      .fu_done  (fu_done),
      .fu_tag   (fu_tag),
      .state    (st[g]),
      .op       (op_e[g]),
      .vj       (vj_e[g]),
      .vk       (vk_e[g]),
      .a        (a_e[g]),
      .rd       (rd_e[g])
    );

    assign busy_vec[g]        = (st[g] != RS_FREE);
    assign state_dbg[2*g +: 2] = st[g];
  end
endmodule

// File: tb/tb_res_station_bank.sv
// Bench for res_station_bank: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a behavioural model.
module tb_res_station_bank;
  import rs_pkg::*;

  localparam int DEPTH    = 4;
  localparam int BASE_TAG = 1;

  logic               clk, rst;
  logic               issue_valid, issue_ready;
  logic [OP_W-1:0]    issue_op;
  logic [DATA_W-1:0]  issue_vj, issue_vk;
  logic [TAG_W-1:0]   issue_qj, issue_qk, issue_tag;
  logic [IMM_W-1:0]   issue_a;
  logic [2:0]         issue_rd;
  logic               cdb_valid;
  logic [TAG_W-1:0]   cdb_tag;
  logic [DATA_W-1:0]  cdb_value;
  logic               disp_valid, disp_ready;
  logic [OP_W-1:0]    disp_op;
  logic [DATA_W-1:0]  disp_vj, disp_vk;
  logic [IMM_W-1:0]   disp_a;
  logic [2:0]         disp_rd;
  logic [TAG_W-1:0]   disp_tag;
  logic               fu_done;
  logic [TAG_W-1:0]   fu_tag;
  logic [DEPTH-1:0]   busy_vec;
  logic               full;
  logic [2*DEPTH-1:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  res_station_bank #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .IMM_W(IMM_W),
    .DEPTH(DEPTH), .BASE_TAG(BASE_TAG)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_a(issue_a),
    .issue_rd(issue_rd), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_a(disp_a), .disp_rd(disp_rd), .disp_tag(disp_tag),
    .fu_done(fu_done), .fu_tag(fu_tag),
    .busy_vec(busy_vec), .full(full), .state_dbg(state_dbg)
  );

  // ---------------- clock / timeout ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // ---------------- checker ----------------
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Entry lifecycle codes: 0 free, 1 waiting for operands, 2 ready, 3 executing.
  int      m_st  [DEPTH];
  rs_rec_t m_rec [DEPTH];

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_st[i]  = 0;
      m_rec[i] = '0;
    end
  endfunction

  function automatic int first_with(int s);
    for (int i = 0; i < DEPTH; i++) if (m_st[i] == s) return i;
    return -1;
  endfunction

  function automatic void check_model();
    int f = first_with(0);
    int r = first_with(2);
    logic [DEPTH-1:0] b;
    for (int i = 0; i < DEPTH; i++) b[i] = (m_st[i] != 0);
    chk("busy_vec", busy_vec, b);
    chk("full", full, f < 0);
    chk("issue_ready", issue_ready, f >= 0);
    chk("issue_tag", issue_tag, (f < 0) ? BASE_TAG : BASE_TAG + f);
    chk("disp_valid", disp_valid, r >= 0);
    chk("disp_op", disp_op, (r >= 0) ? m_rec[r].op : 0);
    chk("disp_vj", disp_vj, (r >= 0) ? m_rec[r].vj : 0);
    chk("disp_vk", disp_vk, (r >= 0) ? m_rec[r].vk : 0);
    chk("disp_a", disp_a, (r >= 0) ? m_rec[r].a : 0);
    chk("disp_rd", disp_rd, (r >= 0) ? m_rec[r].rd : 0);
    chk("disp_tag", disp_tag, (r >= 0) ? BASE_TAG + r : 0);
  endfunction

  // Applies one clock edge's worth of rules using only pre-edge model state.
  function automatic void model_step();
    int f = first_with(0);
    int r = first_with(2);
    int      ns [DEPTH];
    rs_rec_t nr [DEPTH];
    for (int i = 0; i < DEPTH; i++) begin
      ns[i] = m_st[i];
      nr[i] = m_rec[i];
      if (m_st[i] == 3 && fu_done && int'(fu_tag) == BASE_TAG + i) begin
        ns[i] = 0;
        nr[i] = '0;
      end
      if (m_st[i] == 2 && i == r && disp_ready) ns[i] = 3;
      if (m_st[i] == 1 && cdb_valid && cdb_tag != 0) begin
        if (nr[i].qj == cdb_tag) begin nr[i].vj = cdb_value; nr[i].qj = 0; end
        if (nr[i].qk == cdb_tag) begin nr[i].vk = cdb_value; nr[i].qk = 0; end
        if (nr[i].qj == 0 && nr[i].qk == 0) ns[i] = 2;
      end
    end
    if (issue_valid && f >= 0) begin
      nr[f].op = issue_op;
      nr[f].a  = issue_a;
      nr[f].rd = issue_rd;
      nr[f].vj = issue_vj;
      nr[f].qj = issue_qj;
      nr[f].vk = issue_vk;
      nr[f].qk = issue_qk;
      if (cdb_valid && issue_qj != 0 && issue_qj == cdb_tag) begin
        nr[f].vj = cdb_value; nr[f].qj = 0;
      end
      if (cdb_valid && issue_qk != 0 && issue_qk == cdb_tag) begin
        nr[f].vk = cdb_value; nr[f].qk = 0;
      end
      ns[f] = (nr[f].qj == 0 && nr[f].qk == 0) ? 2 : 1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      m_st[i]  = ns[i];
      m_rec[i] = nr[i];
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    issue_valid = 0; issue_op = 0; issue_vj = 0; issue_vk = 0;
    issue_qj = 0; issue_qk = 0; issue_a = 0; issue_rd = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
    disp_ready = 0; fu_done = 0; fu_tag = 0;
  endtask

  task automatic drive_issue(input int op, input int vj, input int vk,
                             input int qj, input int qk, input int a, input int rd);
    issue_valid = 1;
    issue_op = OP_W'(op); issue_vj = DATA_W'(vj); issue_vk = DATA_W'(vk);
    issue_qj = TAG_W'(qj); issue_qk = TAG_W'(qk);
    issue_a = IMM_W'(a); issue_rd = 3'(rd);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    check_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic              iv;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic [IMM_W-1:0]  a;
    logic [2:0]        rd;
    logic              cv;
    logic [TAG_W-1:0]  ct;
    logic [DATA_W-1:0] cval;
    logic              dr;
    logic              fd;
    logic [TAG_W-1:0]  ft;
    logic [DEPTH-1:0]  e_busy;
    logic              e_dv;
    logic [TAG_W-1:0]  e_dtag;
    logic [DATA_W-1:0] e_dvj;
    logic [TAG_W-1:0]  e_itag;
  } vec_t;

  vec_t vecs [14];

  initial begin
    // Expected values are the outputs just after the edge that applies the row.
    //          iv op vj vk     qj qk a  rd  cv ct cval     dr fd ft  busy  dv dtag dvj      itag
    vecs[0]  = '{1, 3, 5, 7,     0, 0, 1, 2,  0, 0, 0,       0, 0, 0, 4'h1, 1, 1,  5,       2};
    vecs[1]  = '{1, 1, 0, 3,     6, 0, 0, 1,  0, 0, 0,       0, 0, 0, 4'h3, 1, 1,  5,       3};
    vecs[2]  = '{0, 0, 0, 0,     0, 0, 0, 0,  1, 6, 16'h42,  0, 0, 0, 4'h3, 1, 1,  5,       3};
    vecs[3]  = '{0, 0, 0, 0,     0, 0, 0, 0,  0, 0, 0,       1, 0, 0, 4'h3, 1, 2,  16'h42,  3};
    vecs[4]  = '{1, 2, 0, 1,     4, 0, 0, 0,  1, 4, 9,       1, 0, 0, 4'h7, 1, 3,  9,       4};
    vecs[5]  = '{0, 0, 0, 0,     0, 0, 0, 0,  0, 0, 0,       0, 1, 7, 4'h7, 1, 3,  9,       4};
    vecs[6]  = '{0, 0, 0, 0,     0, 0, 0, 0,  0, 0, 0,       0, 1, 1, 4'h6, 1, 3,  9,       1};
    vecs[7]  = '{0, 0, 0, 0,     0, 0, 0, 0,  0, 0, 0,       1, 1, 2, 4'h4, 0, 0,  0,       1};
    vecs[8]  = '{0, 0, 0, 0,     0, 0, 0, 0,  0, 0, 0,       0, 1, 3, 4'h0, 0, 0,  0,       1};
    vecs[9]  = '{1, 5, 0, 8,     2, 0, 3, 4,  0, 0, 0,       0, 0, 0, 4'h1, 0, 0,  0,       2};
    vecs[10] = '{0, 0, 0, 0,     0, 0, 0, 0,  0, 0, 0,       0, 0, 0, 4'h1, 0, 0,  0,       2};
    vecs[11] = '{0, 0, 0, 0,     0, 0, 0, 0,  1, 2, 16'h42,  0, 0, 0, 4'h1, 1, 1,  16'h42,  2};
    vecs[12] = '{0, 0, 0, 0,     0, 0, 0, 0,  0, 0, 0,       1, 0, 0, 4'h1, 0, 0,  0,       2};
    vecs[13] = '{0, 0, 0, 0,     0, 0, 0, 0,  0, 0, 0,       0, 1, 1, 4'h0, 0, 0,  0,       1};
  end

  // ---------------- main sequence ----------------
  initial begin
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    do_reset();
    chk("reset busy_vec", busy_vec, 0);
    chk("reset full", full, 0);
    chk("reset issue_ready", issue_ready, 1);
    chk("reset issue_tag", issue_tag, BASE_TAG);
    chk("reset disp_valid", disp_valid, 0);
    chk("reset disp_tag", disp_tag, 0);

    // Directed table
    for (int v = 0; v < 14; v++) begin
      issue_valid = vecs[v].iv; issue_op = vecs[v].op;
      issue_vj = vecs[v].vj; issue_vk = vecs[v].vk;
      issue_qj = vecs[v].qj; issue_qk = vecs[v].qk;
      issue_a = vecs[v].a; issue_rd = vecs[v].rd;
      cdb_valid = vecs[v].cv; cdb_tag = vecs[v].ct; cdb_value = vecs[v].cval;
      disp_ready = vecs[v].dr; fu_done = vecs[v].fd; fu_tag = vecs[v].ft;
      cycle();
      chk($sformatf("vec%0d busy_vec", v), busy_vec, vecs[v].e_busy);
      chk($sformatf("vec%0d disp_valid", v), disp_valid, vecs[v].e_dv);
      chk($sformatf("vec%0d disp_tag", v), disp_tag, vecs[v].e_dtag);
      chk($sformatf("vec%0d disp_vj", v), disp_vj, vecs[v].e_dvj);
      chk($sformatf("vec%0d issue_tag", v), issue_tag, vecs[v].e_itag);
    end

    // Fill, free-while-full, reuse of the freed slot, priority, stray completion
    do_reset();
    drive_issue(1, 1, 1, 5, 0, 0, 0); cycle();
    cycle();
    drive_issue(2, 4, 4, 0, 0, 0, 0); cycle();
    drive_issue(1, 1, 1, 5, 0, 0, 0); cycle();
    chk("fill full", full, 1);
    chk("fill issue_ready", issue_ready, 0);
    chk("fill busy_vec", busy_vec, 4'b1111);
    chk("fill disp_tag", disp_tag, 3);
    disp_ready = 1; cycle();
    chk("dispatch e2 disp_valid", disp_valid, 0);
    disp_ready = 0; fu_done = 1; fu_tag = 3; cycle();
    chk("free e2 busy_vec", busy_vec, 4'b1011);
    chk("free e2 full", full, 0);
    chk("free e2 issue_tag", issue_tag, 3);
    fu_done = 0; drive_issue(6, 2, 2, 6, 0, 1, 1); cycle();
    chk("reuse e2 busy_vec", busy_vec, 4'b1111);
    issue_valid = 0; cdb_valid = 1; cdb_tag = 5; cdb_value = 16'h77; cycle();
    chk("wake disp_valid", disp_valid, 1);
    chk("wake disp_tag", disp_tag, 1);
    chk("wake disp_vj", disp_vj, 16'h77);
    cdb_valid = 0; disp_ready = 1; cycle();
    chk("priority disp_tag", disp_tag, 2);
    disp_ready = 0; fu_done = 1; fu_tag = 7; cycle();
    chk("stray done busy_vec", busy_vec, 4'b1111);
    chk("stray done disp_tag", disp_tag, 2);
    clear_inputs();

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_op = OP_W'($urandom_range(0, 7));
      issue_vj = DATA_W'($urandom);
      issue_vk = DATA_W'($urandom);
      issue_qj = ($urandom_range(0, 2) == 0) ? '0 : TAG_W'($urandom_range(1, 7));
      issue_qk = ($urandom_range(0, 2) == 0) ? '0 : TAG_W'($urandom_range(1, 7));
      issue_a = IMM_W'($urandom_range(0, 127));
      issue_rd = 3'($urandom_range(0, 7));
      cdb_valid = ($urandom_range(0, 1) == 1);
      cdb_tag = TAG_W'($urandom_range(0, 7));
      cdb_value = DATA_W'($urandom);
      disp_ready = ($urandom_range(0, 2) != 0);
      fu_done = ($urandom_range(0, 1) == 1);
      fu_tag = ($urandom_range(0, 4) == 0) ? TAG_W'($urandom_range(0, 7))
                                            : TAG_W'($urandom_range(1, 4));
      cycle();
    end
    clear_inputs();

    // Asynchronous reset with work in flight
    do_reset();
    drive_issue(1, 10, 11, 0, 0, 2, 3); cycle();
    drive_issue(2, 12, 13, 0, 0, 4, 5); cycle();
    drive_issue(3, 14, 15, 0, 6, 6, 7); cycle();
    chk("pre-reset busy_vec", busy_vec, 4'b0111);
    chk("pre-reset disp_valid", disp_valid, 1);
    clear_inputs();
    #2 rst = 1;
    #1;
    chk("async reset busy_vec", busy_vec, 0);
    chk("async reset disp_valid", disp_valid, 0);
    chk("async reset disp_vj", disp_vj, 0);
    chk("async reset full", full, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    #1;
    check_model();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
